uart_receiver: RTL and testbench

Bus-attached UART receive device: the counterpart of the transmit-only `uart` on the `ibex_demo_system` bus. It deserialises 8N1 frames from a serial input using mid-bit sampling and buffers received bytes in a FIFO. Software reads it through the standard device request/rvalid interface, and it raises a level interrupt for the core's fast-interrupt inputs. It occupies one 4 KiB window on the bus; only offsets 0x0–0x8 are decoded.

---
 rtl/uart_receiver.sv | 204 ++++++++++++++++++++
 tb/tb_uart_receiver.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/uart_receiver.sv
// uart_receiver: bus-attached 8N1 UART receiver. It samples each bit in the
// middle, buffers received bytes in a FIFO, and raises a level interrupt.
//
//   state | meaning
//   ------+-----------------------------------------------------
//   IDLE  | line idle, waiting for a falling edge on rx_s
//   START | counting to mid start bit, rejecting false starts
//   DATA  | sampling 8 data bits LSB first at mid-bit
//   STOP  | sampling stop bit, then push byte or flag frame_err
module uart_receiver #(
  parameter int ClockFrequency = 50_000_000,
  parameter int BaudRate       = 115_200,
  parameter int RxFifoDepth    = 8
) (
  input  logic        clk_sys_i,
  input  logic        rst_sys_ni,
  input  logic        device_req_i,
  input  logic [31:0] device_addr_i,
  input  logic        device_we_i,
  input  logic [3:0]  device_be_i,
  input  logic [31:0] device_wdata_i,
  output logic        device_rvalid_o,
  output logic [31:0] device_rdata_o,
  input  logic        uart_rx_i,
  output logic        rx_irq_o
);

  localparam int ClocksPerBit = ClockFrequency / BaudRate;
  localparam int CntW         = $clog2(ClocksPerBit);
  localparam int AW           = $clog2(RxFifoDepth);

  localparam logic [CntW-1:0] BitLoad   = CntW'(ClocksPerBit - 1);
  // The edge-detect cycle is itself the first cycle of the half bit, so the
  // start sample lands ClocksPerBit/2 - 1 cycles after it.
  localparam logic [CntW-1:0] StartLoad = CntW'(ClocksPerBit / 2 - 2);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] START = 2'd1;
  localparam logic [1:0] DATA  = 2'd2;
  localparam logic [1:0] STOP  = 2'd3;

  logic            rx_meta, rx_s, rx_prev;
  logic [1:0]      state;
  logic [CntW-1:0] cnt;
  logic [2:0]      bit_cnt;
  logic [7:0]      shreg;

  logic [7:0]      mem [RxFifoDepth];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [AW:0]     count;
  logic            empty, full;

  logic            stop_hit, push_req, push, pop, ovr_set, ferr_set;
  logic            sts_wr, ctrl_wr;
  logic            overrun, frame_err, irq_en;
  logic [7:0]      head;
  logic [31:0]     rd_mux;
  logic            unused_bus;

  assign unused_bus = ^{device_be_i, device_addr_i[31:4], device_addr_i[1:0],
                        device_wdata_i[31:4], device_wdata_i[1]};

  // Two-flop synchronizer plus one delayed copy for edge detection.
  always_ff @(posedge clk_sys_i or negedge rst_sys_ni) begin
    if (!rst_sys_ni) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= uart_rx_i;
      rx_s    <= rx_meta;
      rx_prev <= rx_s;
    end
  end

  // Receive FSM with down-counting bit timer.
  always_ff @(posedge clk_sys_i or negedge rst_sys_ni) begin
    if (!rst_sys_ni) begin
      state   <= IDLE;
      cnt     <= '0;
      bit_cnt <= '0;
      shreg   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (rx_prev && !rx_s) begin
            cnt   <= StartLoad;
            state <= START;
          end
        end
        START: begin
          if (cnt == '0) begin
            if (rx_s) begin
              state <= IDLE;
            end else begin
              cnt     <= BitLoad;
              bit_cnt <= '0;
              state   <= DATA;
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        DATA: begin
          if (cnt == '0) begin
            shreg <= {rx_s, shreg[7:1]};
            cnt   <= BitLoad;
            if (bit_cnt == 3'd7) begin
              state <= STOP;
            end else begin
              bit_cnt <= bit_cnt + 3'd1;
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        STOP: begin
          if (cnt == '0) begin
            state <= IDLE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign stop_hit = (state == STOP) && (cnt == '0);
  assign push_req = stop_hit && rx_s;
  assign ferr_set = stop_hit && !rx_s;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(RxFifoDepth));
  assign sts_wr  = device_req_i && device_we_i && (device_addr_i[3:2] == 2'd1);
  assign ctrl_wr = device_req_i && device_we_i && (device_addr_i[3:2] == 2'd2);
  assign pop     = device_req_i && !device_we_i && (device_addr_i[3:2] == 2'd0) && !empty;
  // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
  assign push    = push_req && (!full || pop);
  assign ovr_set = push_req && full && !pop;
  assign head    = empty ? 8'h00 : mem[rd_ptr];

  // FIFO storage; contents need no reset since empty masks the head.
  always_ff @(posedge clk_sys_i) begin
    if (push) begin
      mem[wr_ptr] <= shreg;
    end
  end

  // FIFO pointers and fill level.
  always_ff @(posedge clk_sys_i or negedge rst_sys_ni) begin
    if (!rst_sys_ni) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Sticky flags (set beats W1C) and interrupt enable.
  always_ff @(posedge clk_sys_i or negedge rst_sys_ni) begin
    if (!rst_sys_ni) begin
      overrun   <= 1'b0;
      frame_err <= 1'b0;
      irq_en    <= 1'b0;
    end else begin
      overrun   <= ovr_set  || (overrun   && !(sts_wr && device_wdata_i[2]));
      frame_err <= ferr_set || (frame_err && !(sts_wr && device_wdata_i[3]));
      if (ctrl_wr) irq_en <= device_wdata_i[0];
    end
  end

  // Read data mux.
  always_comb begin
    rd_mux = '0;
    case (device_addr_i[3:2])
      2'd0:    rd_mux = {24'h0, head};
      2'd1:    rd_mux = {16'h0, 8'(count), 4'h0, frame_err, overrun, full, !empty};
      2'd2:    rd_mux = {31'h0, irq_en};
      default: rd_mux = '0;
    endcase
  end

  // Registered bus response and interrupt.
  always_ff @(posedge clk_sys_i or negedge rst_sys_ni) begin
    if (!rst_sys_ni) begin
      device_rvalid_o <= 1'b0;
      device_rdata_o  <= '0;
      rx_irq_o        <= 1'b0;
    end else begin
      device_rvalid_o <= device_req_i;
      device_rdata_o  <= (device_req_i && !device_we_i) ? rd_mux : '0;
      rx_irq_o        <= irq_en && (!empty || overrun || frame_err);
    end
  end

endmodule

// File: tb/tb_uart_receiver.sv
// Directed bench for uart_receiver at 434 clocks per bit.
module tb_uart_receiver;

  localparam int CPB      = 434;
  localparam int STOP_IDX = 9 * CPB + 219;   // negedge index right after stop sample

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req = 1'b0;
  logic [31:0] addr = '0;
  logic        we = 1'b0;
  logic [3:0]  be = 4'hF;
  logic [31:0] wdata = '0;
  logic        rvalid;
  logic [31:0] rdata;
  logic        rx = 1'b1;
  logic        irq;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp;
    string       name;
  } vec_t;

  vec_t vecs[9];

  always #5 clk = ~clk;

  uart_receiver dut (
    .clk_sys_i      (clk),
    .rst_sys_ni     (rst_n),
    .device_req_i   (req),
    .device_addr_i  (addr),
    .device_we_i    (we),
    .device_be_i    (be),
    .device_wdata_i (wdata),
    .device_rvalid_o(rvalid),
    .device_rdata_o (rdata),
    .uart_rx_i      (rx),
    .rx_irq_o       (irq)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic bus(input logic w, input logic [31:0] a, input logic [31:0] d,
                     output logic [31:0] rd);
    @(negedge clk);
    req = 1'b1; we = w; addr = a; wdata = d;
    @(negedge clk);
    req = 1'b0; we = 1'b0;
    check("rvalid", {31'h0, rvalid}, 32'h1);
    rd = rdata;
  endtask

  task automatic rd_check(input string name, input logic [31:0] a, input logic [31:0] exp);
    logic [31:0] v;
    bus(1'b0, a, 32'h0, v);
    check(name, v, exp);
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    logic [31:0] v;
    bus(1'b1, a, d, v);
    check("write_rdata", v, 32'h0);
  endtask

  // One full 10-bit frame; optional RXDATA read whose request edge is the
  // stop sample edge, and optional check of irq rise timing.
  task automatic send_frame(input logic [7:0] d, input logic stop_bit, input int pop_at,
                            input logic [7:0] pop_exp, input bit irq_chk);
    int b;
    for (int i = 0; i < 10 * CPB; i++) begin
      @(negedge clk);
      b = i / CPB;
      if (b == 0)      rx = 1'b0;
      else if (b == 9) rx = stop_bit;
      else             rx = d[b-1];
      if (pop_at >= 0 && i == pop_at) begin
        req = 1'b1; we = 1'b0; addr = 32'h0;
      end else if (pop_at >= 0 && i == pop_at + 1) begin
        req = 1'b0;
        check("pop_rvalid", {31'h0, rvalid}, 32'h1);
        check("pop_rdata", rdata, {24'h0, pop_exp});
      end
      if (irq_chk && i == STOP_IDX) check("irq_before_rise", {31'h0, irq}, 32'h0);
      if (irq_chk && i == STOP_IDX + 1) check("irq_rise", {31'h0, irq}, 32'h1);
    end
  endtask

  initial begin
    logic [31:0] v;

    vecs[0] = '{1'b0, 32'h4, 32'h0,        32'h0, "rst_status"};
    vecs[1] = '{1'b0, 32'h8, 32'h0,        32'h0, "rst_ctrl"};
    vecs[2] = '{1'b0, 32'h0, 32'h0,        32'h0, "rst_rxdata"};
    vecs[3] = '{1'b0, 32'hC, 32'h0,        32'h0, "rd_0xC"};
    vecs[4] = '{1'b1, 32'h8, 32'hFFFFFFFF, 32'h0, "wr_ctrl_rdata"};
    vecs[5] = '{1'b0, 32'h8, 32'h0,        32'h1, "ctrl_set"};
    vecs[6] = '{1'b1, 32'h8, 32'h0,        32'h0, "wr_ctrl0_rdata"};
    vecs[7] = '{1'b0, 32'h8, 32'h0,        32'h0, "ctrl_clr"};
    vecs[8] = '{1'b1, 32'h0, 32'hFF,       32'h0, "wr_rxdata_rdata"};

    repeat (3) @(negedge clk);
    check("rst_rvalid", {31'h0, rvalid}, 32'h0);
    check("rst_rdata", rdata, 32'h0);
    check("rst_irq", {31'h0, irq}, 32'h0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 9; i++) begin
      bus(vecs[i].we, vecs[i].addr, vecs[i].wdata, v);
      check(vecs[i].name, v, vecs[i].exp);
      @(negedge clk);
      check("rvalid_one_cycle", {31'h0, rvalid}, 32'h0);
    end
    rd_check("status_after_wr_rxdata", 32'h4, 32'h0);
    check("irq_idle", {31'h0, irq}, 32'h0);

    // single byte
    send_frame(8'hA5, 1'b1, -1, 8'h00, 1'b0);
    rd_check("a5_status", 32'h4, 32'h0000_0101);
    rd_check("a5_data", 32'h0, 32'hA5);
    rd_check("a5_status_after", 32'h4, 32'h0);
    rd_check("empty_read", 32'h0, 32'h0);

    // false start glitch
    @(negedge clk); rx = 1'b0;
    repeat (100) @(negedge clk);
    rx = 1'b1;
    repeat (500) @(negedge clk);
    rd_check("glitch_status", 32'h4, 32'h0);

    // stream with interrupt
    wr(32'h8, 32'h1);
    check("irq_en_empty", {31'h0, irq}, 32'h0);
    send_frame(8'h00, 1'b1, -1, 8'h00, 1'b1);
    send_frame(8'hFF, 1'b1, -1, 8'h00, 1'b0);
    send_frame(8'h3C, 1'b1, -1, 8'h00, 1'b0);
    check("irq_stream", {31'h0, irq}, 32'h1);
    rd_check("stream_status", 32'h4, 32'h0000_0301);
    rd_check("stream_0", 32'h0, 32'h00);
    rd_check("stream_1", 32'h0, 32'hFF);
    rd_check("stream_2", 32'h0, 32'h3C);
    check("irq_at_last_pop", {31'h0, irq}, 32'h1);
    @(negedge clk);
    check("irq_fall", {31'h0, irq}, 32'h0);
    wr(32'h8, 32'h0);

    // framing error
    send_frame(8'h55, 1'b0, -1, 8'h00, 1'b0);
    @(negedge clk); rx = 1'b1;
    repeat (20) @(negedge clk);
    rd_check("ferr_status", 32'h4, 32'h8);
    rd_check("ferr_empty", 32'h0, 32'h0);
    wr(32'h4, 32'h8);
    rd_check("ferr_clear", 32'h4, 32'h0);

    // fill, pop while full, then overrun
    for (int i = 1; i <= 8; i++) send_frame(8'(i), 1'b1, -1, 8'h00, 1'b0);
    rd_check("full_status", 32'h4, 32'h0000_0803);
    send_frame(8'h09, 1'b1, STOP_IDX - 1, 8'h01, 1'b0);
    rd_check("pop_full_status", 32'h4, 32'h0000_0803);
    send_frame(8'h0A, 1'b1, -1, 8'h00, 1'b0);
    rd_check("overrun_status", 32'h4, 32'h0000_0807);
    for (int i = 2; i <= 9; i++) rd_check("drain", 32'h0, 32'(i));
    rd_check("drained_status", 32'h4, 32'h4);
    wr(32'h4, 32'h4);
    rd_check("overrun_clear", 32'h4, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
